// File: rtl/bali_ctrl_pkg.sv
// bali_ctrl_pkg: shared state encoding and stack access constants for the stack execution controller.
package bali_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP_REQ   = 3'd1,
        POP_WAIT  = 3'd2,
        EXEC      = 3'd3,
        PUSH_REQ  = 3'd4,
        PUSH_WAIT = 3'd5,
        DONE      = 3'd6
    } ctrl_state_t;

    localparam logic STK_POP  = 1'b0;
    localparam logic STK_PUSH = 1'b1;

endpackage

// File: rtl/operand_buf.sv
// operand_buf: N x DW operand register file with indexed write and flat read-out.
module operand_buf #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [IW-1:0]   idx_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [N*DW-1:0] rdata_o
);

    logic [N-1:0][DW-1:0] regs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs_q <= '0;
        else if (we_i && int'(idx_i) < N)
            regs_q[idx_i] <= wdata_i;
    end

    assign rdata_o = regs_q;

endmodule

// File: rtl/stack_exec_ctrl.sv
// stack_exec_ctrl: sequences operand pops, ALU settling and result pushes for one decoded instruction.
module stack_exec_ctrl
    import bali_ctrl_pkg::*;
#(
    parameter int DW       = 32,
    parameter int MAX_ARGS = 3,
    parameter int DEPTH    = 256,
    parameter int CW       = $clog2(MAX_ARGS + 1),
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [CW-1:0]          pop_count_i,
    input  logic [1:0]             push_count_i,
    input  logic                   const_push_i,
    input  logic [DW-1:0]          const_val_i,
    input  logic [DW-1:0]          alu_lo_i,
    input  logic [DW-1:0]          alu_hi_i,
    output logic [MAX_ARGS*DW-1:0] operands_o,
    output logic                   stk_trigger_o,
    output logic                   stk_push_o,
    output logic [DW-1:0]          stk_wdata_o,
    input  logic [DW-1:0]          stk_rdata_i,
    input  logic                   stk_done_i,
    input  logic [SW-1:0]          stk_depth_i,
    output logic                   busy_o,
    output logic                   op_done_o,
    output logic                   error_o
);

    localparam int XW = (SW > CW ? SW : CW) + 2;

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [1:0]    push_q, push_d;
    logic          cp_q, cp_d;
    logic [DW-1:0] cv_q, cv_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          op_we;
    logic [1:0]    push_eff;
    logic          uf, of;

    assign push_eff = push_count_i[1] ? 2'd2 : push_count_i;
    // Overflow compared as depth + push > DEPTH + pop so no intermediate goes negative
    assign uf = XW'(stk_depth_i) < XW'(pop_count_i);
    assign of = XW'(stk_depth_i) + XW'(push_eff) > XW'(DEPTH) + XW'(pop_count_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            push_q  <= '0;
            cp_q    <= 1'b0;
            cv_q    <= '0;
            hi_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            push_q  <= push_d;
            cp_q    <= cp_d;
            cv_q    <= cv_d;
            hi_q    <= hi_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        push_d  = push_q;
        cp_d    = cp_q;
        cv_d    = cv_q;
        hi_d    = hi_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        op_we   = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                rem_d   = pop_count_i;
                push_d  = push_eff;
                cp_d    = const_push_i;
                cv_d    = const_val_i;
                err_d   = uf | of;
                state_d = (uf | of) ? DONE : (pop_count_i != '0 ? POP_REQ : EXEC);
            end
            POP_REQ: state_d = POP_WAIT;
            POP_WAIT: if (stk_done_i) begin
                op_we   = 1'b1;
                rem_d   = rem_q - CW'(1);
                state_d = (rem_q > CW'(1)) ? POP_REQ : EXEC;
            end
            EXEC: begin
                hi_d    = alu_hi_i;
                wdata_d = (push_q != 2'd0) ? (cp_q ? cv_q : alu_lo_i) : wdata_q;
                state_d = (push_q != 2'd0) ? PUSH_REQ : DONE;
            end
            PUSH_REQ: state_d = PUSH_WAIT;
            PUSH_WAIT: if (stk_done_i) begin
                push_d  = push_q - 2'd1;
                wdata_d = (push_q == 2'd2) ? (cp_q ? cv_q : hi_q) : wdata_q;
                state_d = (push_q == 2'd2) ? PUSH_REQ : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // First pop is the top of stack and lands in the highest used slot
    operand_buf #(
        .N (MAX_ARGS),
        .DW(DW),
        .IW(CW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .we_i   (op_we),
        .idx_i  (rem_q - CW'(1)),
        .wdata_i(stk_rdata_i),
        .rdata_o(operands_o)
    );

    assign stk_trigger_o = (state_q == POP_REQ) || (state_q == PUSH_REQ);
    assign stk_push_o    = (state_q == PUSH_REQ || state_q == PUSH_WAIT) ? STK_PUSH : STK_POP;
    assign stk_wdata_o   = wdata_q;
    assign busy_o        = state_q != IDLE;
    assign op_done_o     = state_q == DONE;
    assign error_o       = err_q;

endmodule

// File: tb/tb_stack_exec_ctrl.sv
// tb_stack_exec_ctrl: vector table plus stall/reset sequences against a behavioural stack and ALU.
module tb_stack_exec_ctrl;

    localparam int DW       = 32;
    localparam int MAX_ARGS = 3;
    localparam int DEPTH    = 256;
    localparam int CW       = 2;
    localparam int SW       = 9;

    logic                   clk = 0;
    logic                   rst;
    logic                   start;
    logic [CW-1:0]          pop_count;
    logic [1:0]             push_count;
    logic                   const_push;
    logic [DW-1:0]          const_val;
    logic [DW-1:0]          alu_lo, alu_hi;
    logic [MAX_ARGS*DW-1:0] operands;
    logic                   stk_trigger, stk_push;
    logic [DW-1:0]          stk_wdata, stk_rdata;
    logic                   stk_done;
    logic [SW-1:0]          stk_depth;
    logic                   busy, op_done, error;

    stack_exec_ctrl #(.DW(DW), .MAX_ARGS(MAX_ARGS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start), .pop_count_i(pop_count),
        .push_count_i(push_count), .const_push_i(const_push), .const_val_i(const_val),
        .alu_lo_i(alu_lo), .alu_hi_i(alu_hi), .operands_o(operands),
        .stk_trigger_o(stk_trigger), .stk_push_o(stk_push), .stk_wdata_o(stk_wdata),
        .stk_rdata_i(stk_rdata), .stk_done_i(stk_done), .stk_depth_i(stk_depth),
        .busy_o(busy), .op_done_o(op_done), .error_o(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: add slots 0 and 1, or fixed words for the multiply-like case
    logic          fixed = 0;
    logic [DW-1:0] fix_lo = 0, fix_hi = 0;
    assign alu_lo = fixed ? fix_lo : operands[DW-1:0] + operands[2*DW-1:DW];
    assign alu_hi = fixed ? fix_hi : '0;

    // Behavioural stack answering lat_d cycles after each trigger
    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] got [0:63];
    logic [DW-1:0] ld_data [0:7];
    logic [DW-1:0] wd;
    logic          ld = 0, op, pend;
    int            ld_n = 0, lat_d = 1, sp, cnt;
    int            got_n = 0, trig_cnt = 0, done_cnt = 0, unstable = 0;

    assign stk_depth = sp[SW-1:0];

    always @(posedge clk or posedge rst) begin : stack_model
        bit            go;
        logic          ap;
        logic [DW-1:0] av;
        if (rst) begin
            sp <= 0; pend <= 0; cnt <= 0; stk_done <= 0; stk_rdata <= '0; op <= 0; wd <= '0;
        end else begin
            go = 0; ap = 0; av = '0;
            stk_done <= 0;
            if (op_done) done_cnt <= done_cnt + 1;
            if (ld) begin
                for (int i = 0; i < 8; i++) mem[i] <= ld_data[i];
                sp <= ld_n;
            end
            if (stk_trigger) begin
                trig_cnt <= trig_cnt + 1; op <= stk_push; wd <= stk_wdata;
                if (lat_d <= 1) begin go = 1; ap = stk_push; av = stk_wdata; end
                else begin pend <= 1; cnt <= lat_d - 1; end
            end else if (pend) begin
                if (stk_push !== op || (op && stk_wdata !== wd)) unstable <= unstable + 1;
                if (cnt == 1) begin go = 1; ap = op; av = wd; pend <= 0; end
                else cnt <= cnt - 1;
            end
            if (go) begin
                stk_done <= 1;
                if (ap) begin
                    mem[sp] <= av; sp <= sp + 1; got[got_n] <= av; got_n <= got_n + 1;
                end else begin
                    stk_rdata <= mem[sp-1]; sp <= sp - 1;
                end
            end
        end
    end

    int checks = 0, errors = 0, got_rd = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm);
        while (exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (got_rd < got_n) begin
                chk({nm, "_push"}, got[got_rd], e);
                got_rd++;
            end else chk({nm, "_push_missing"}, 0, 1);
        end
        chk({nm, "_push_extra"}, got_n - got_rd, 0);
        got_rd = got_n;
    endtask

    task automatic load(input int n, input logic [DW-1:0] a, b, c);
        @(posedge clk); #1;
        ld_data[0] = a; ld_data[1] = b; ld_data[2] = c;
        for (int i = 3; i < 8; i++) ld_data[i] = '0;
        ld_n = n; ld = 1;
        @(posedge clk); #1;
        ld = 0;
    endtask

    task automatic do_op(input int p, q, input bit cp, input logic [DW-1:0] cv,
                         input bit fx, input logic [DW-1:0] lo, hi, input int rs,
                         output int lat, output bit err);
        int t0;
        @(posedge clk); #1;
        fixed = fx; fix_lo = lo; fix_hi = hi;
        pop_count = CW'(p); push_count = 2'(q); const_push = cp; const_val = cv;
        start = 1; t0 = cyc;
        @(posedge clk); #1;
        start = 0; pop_count = '0; push_count = '0; const_push = !cp; const_val = 32'h1234_5678;
        lat = -1; err = 0;
        for (int n = 0; n < 200; n++) begin
            if (op_done) begin lat = cyc - t0; err = error; break; end
            start = (rs > 0 && cyc - t0 == rs);
            @(posedge clk); #1;
        end
        start = 0;
    endtask

    typedef struct {
        int ldn; logic [DW-1:0] l0, l1, l2;
        int p, q; bit cp; logic [DW-1:0] cv;
        bit fx; logic [DW-1:0] lo, hi;
        int lat; bit err; int np; logic [DW-1:0] e0, e1;
        int ntrig; int dep; logic [DW-1:0] o0, o1, o2;
    } vec_t;

    vec_t vt [10];

    initial begin
        int  lat, t_tr, t_dn, t_un;
        bit  err, found;
        vt[0] = '{2, 7, 5, 0,      2, 1, 0, 0,           0, 0, 0,                8, 0, 1, 12, 0,                   3, 1,   7, 5, 0};
        vt[1] = '{2, 3, 4, 0,      2, 2, 0, 0,           1, 32'hDEADBEEF, 1,     10, 0, 2, 32'hDEADBEEF, 1,        4, 2,   3, 4, 0};
        vt[2] = '{1, 9, 0, 0,      0, 1, 1, 32'hFFFFFFFF, 0, 0, 0,               4, 0, 1, 32'hFFFFFFFF, 0,         1, 2,   3, 4, 0};
        vt[3] = '{1, 9, 0, 0,      2, 0, 0, 0,           0, 0, 0,                1, 1, 0, 0, 0,                    0, 1,   3, 4, 0};
        vt[4] = '{256, 0, 0, 0,    0, 1, 1, 5,           0, 0, 0,                1, 1, 0, 0, 0,                    0, 256, 3, 4, 0};
        vt[5] = '{0, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0,                2, 0, 0, 0, 0,                    0, 0,   3, 4, 0};
        vt[6] = '{1, 1, 0, 0,      1, 3, 1, 32'hA5,      0, 0, 0,                8, 0, 2, 32'hA5, 32'hA5,          3, 2,   1, 4, 0};
        vt[7] = '{3, 10, 20, 30,   3, 1, 0, 0,           0, 0, 0,                10, 0, 1, 30, 0,                  4, 1,   10, 20, 30};
        vt[8] = '{255, 0, 0, 0,    0, 1, 1, 32'h77,      0, 0, 0,                4, 0, 1, 32'h77, 0,               1, 256, 10, 20, 30};
        vt[9] = '{256, 0, 0, 0,    1, 2, 1, 32'h66,      0, 0, 0,                1, 1, 0, 0, 0,                    0, 256, 10, 20, 30};

        rst = 1; start = 0; pop_count = '0; push_count = '0; const_push = 0; const_val = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", op_done, 0);
        chk("rst_trig", stk_trigger, 0);
        #10 rst = 0;
        @(posedge clk); #1;
        chk("rst_error", error, 0);
        chk("rst_push", stk_push, 0);
        chk("rst_wdata", stk_wdata, 0);
        chk("rst_operands", operands, 0);

        for (int k = 0; k < 10; k++) begin
            load(vt[k].ldn, vt[k].l0, vt[k].l1, vt[k].l2);
            if (vt[k].np > 0) exp_q.push_back(vt[k].e0);
            if (vt[k].np > 1) exp_q.push_back(vt[k].e1);
            t_tr = trig_cnt;
            do_op(vt[k].p, vt[k].q, vt[k].cp, vt[k].cv, vt[k].fx, vt[k].lo, vt[k].hi, 0, lat, err);
            chk($sformatf("v%0d_latency", k), lat, vt[k].lat);
            chk($sformatf("v%0d_error", k), err, vt[k].err);
            chk($sformatf("v%0d_triggers", k), trig_cnt - t_tr, vt[k].ntrig);
            chk($sformatf("v%0d_op0", k), operands[DW-1:0], vt[k].o0);
            chk($sformatf("v%0d_op1", k), operands[2*DW-1:DW], vt[k].o1);
            chk($sformatf("v%0d_op2", k), operands[3*DW-1:2*DW], vt[k].o2);
            sb_check($sformatf("v%0d", k));
            @(posedge clk); #1;
            chk($sformatf("v%0d_depth", k), sp, vt[k].dep);
            chk($sformatf("v%0d_idle", k), busy, 0);
            chk($sformatf("v%0d_done_pulse", k), op_done, 0);
            chk($sformatf("v%0d_err_hold", k), error, vt[k].err);
        end

        // Slow stack with a second start during the first pop wait
        lat_d = 5;
        load(2, 7, 5, 0);
        exp_q.push_back(12);
        t_tr = trig_cnt; t_dn = done_cnt; t_un = unstable;
        do_op(2, 1, 0, 0, 0, 0, 0, 3, lat, err);
        chk("stall_latency", lat, 20);
        chk("stall_error", err, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_done_count", done_cnt - t_dn, 1);
        chk("stall_triggers", trig_cnt - t_tr, 3);
        chk("stall_stable", unstable - t_un, 0);
        chk("stall_depth", sp, 1);
        sb_check("stall");

        // Asynchronous reset while waiting on the first push
        load(2, 2, 3, 0);
        @(posedge clk); #1;
        fixed = 1; fix_lo = 32'hAAAA; fix_hi = 32'hBBBB;
        pop_count = 2'd2; push_count = 2'd2; const_push = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        found = 0;
        for (int n = 0; n < 100; n++) begin
            if (stk_push && !stk_trigger) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("rstmid_reach_push_wait", found, 1);
        #2 rst = 1;
        #1;
        chk("rstmid_trig", stk_trigger, 0);
        chk("rstmid_push", stk_push, 0);
        chk("rstmid_wdata", stk_wdata, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", op_done, 0);
        chk("rstmid_error", error, 0);
        chk("rstmid_operands", operands, 0);
        @(posedge clk); #3 rst = 0;
        got_rd = got_n;
        lat_d = 1;
        load(2, 7, 5, 0);
        exp_q.push_back(12);
        do_op(2, 1, 0, 0, 0, 0, 0, 0, lat, err);
        chk("after_rst_latency", lat, 8);
        chk("after_rst_error", err, 0);
        chk("after_rst_op0", operands[DW-1:0], 7);
        chk("after_rst_op1", operands[2*DW-1:DW], 5);
        sb_check("after_rst");
        @(posedge clk); #1;
        chk("after_rst_depth", sp, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
